nor_bank: RTL and testbench

NOR_BANK -- requirements
Module: nor_bank

---
 rtl/nor_bank_if.sv | 29 ++
 rtl/nor_bank.sv | 116 +++++++++++
 tb/tb_nor_bank.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/nor_bank_if.sv
// nor_bank_if -- bus bundle for the nor_bank NOR gate array.
//   in       : CHANNELS*WIDTH gate inputs; channel c uses in[c*WIDTH +: WIDTH]
//   hold     : freeze all internal state while high
//   cnt_clr  : synchronous clear of the transition counter
//   y        : CHANNELS NOR outputs
//   xcount   : saturating 16-bit count of output bit transitions
//   settled  : high when no output change is pending in the pipeline
// master drives the inputs (testbench / upstream), slave is the gate bank.
interface nor_bank_if #(
  parameter int WIDTH    = 3,
  parameter int CHANNELS = 1
);
  logic [CHANNELS*WIDTH-1:0] in;
  logic                      hold;
  logic                      cnt_clr;
  logic [CHANNELS-1:0]       y;
  logic [15:0]               xcount;
  logic                      settled;

  modport master (
    output in, hold, cnt_clr,
    input  y, xcount, settled
  );

  modport slave (
    input  in, hold, cnt_clr,
    output y, xcount, settled
  );
endinterface

// File: rtl/nor_bank.sv
// nor_bank -- CHANNELS independent WIDTH-input NOR gates, each with a
// DELAY-cycle propagation pipeline, plus a saturating output-transition
// counter and a pipeline-settled flag.
//   clk  : single clock; inputs captured on the falling edge, pipeline and
//          status advance on the rising edge
//   rst  : asynchronous active-low reset; outputs/stages return to IV
//   bus  : nor_bank_if slave modport (in, hold, cnt_clr, y, xcount, settled)
// Parameters: WIDTH 1..8, CHANNELS 1..32, IV per-channel reset value,
// DELAY 1..8 rising edges from capture to y.

// One channel: falling-edge capture register feeding a rising-edge shift
// pipeline. The lane also reports what its rising-edge update is about to
// do (toggle of y, settledness after update) so the bank can register
// aggregate status in the same edge without a second pipeline copy.
module nor_lane #(
  parameter int   WIDTH = 3,
  parameter int   DELAY = 1,
  parameter logic IV    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic [WIDTH-1:0] in_bits,
  output logic             y,
  output logic             tog,       // y will flip at this rising edge
  output logic             stable_d   // capture and all stages equal y after this edge
);
  logic             nxt;
  logic [DELAY-1:0] stg;
  logic [DELAY-1:0] stg_d;
  logic             y_d;

  // Inputs are looked at only here, so anything that wiggles between
  // falling edges never reaches the pipeline.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst)       nxt <= IV;
    else if (!hold) nxt <= ~|in_bits;
  end

  // stg[0] is stage 1, stg[DELAY-1] is the stage driving y.
  always_comb begin
    stg_d    = stg;
    stg_d[0] = nxt;
    for (int k = 1; k < DELAY; k++) stg_d[k] = stg[k-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       stg <= {DELAY{IV}};
    else if (!hold) stg <= stg_d;
  end

  assign y        = stg[DELAY-1];
  assign y_d      = stg_d[DELAY-1];
  assign tog      = y_d ^ y;
  assign stable_d = (nxt == y_d) && (stg_d == {DELAY{y_d}});
endmodule

module nor_bank #(
  parameter int                  WIDTH    = 3,
  parameter int                  CHANNELS = 1,
  parameter logic [CHANNELS-1:0] IV       = '0,
  parameter int                  DELAY    = 1
) (
  input  logic       clk,
  input  logic       rst,
  nor_bank_if.slave  bus
);
  logic [CHANNELS-1:0] y_l;
  logic [CHANNELS-1:0] tog_l;
  logic [CHANNELS-1:0] stab_l;
  logic [5:0]          pc;       // up to 32 toggles per edge
  logic [16:0]         sum;
  logic [15:0]         xcount_q;
  logic                settled_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    nor_lane #(
      .WIDTH (WIDTH),
      .DELAY (DELAY),
      .IV    (IV[c])
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .hold     (bus.hold),
      .in_bits  (bus.in[c*WIDTH +: WIDTH]),
      .y        (y_l[c]),
      .tog      (tog_l[c]),
      .stable_d (stab_l[c])
    );
  end

  always_comb begin
    pc = '0;
    for (int c = 0; c < CHANNELS; c++) pc = pc + 6'(tog_l[c]);
  end

  // 17-bit sum so the carry out flags saturation directly.
  assign sum = {1'b0, xcount_q} + 17'(pc);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xcount_q  <= '0;
      settled_q <= 1'b0;
    end else if (!bus.hold) begin
      settled_q <= &stab_l;
      // clear wins over any transitions landing in the same cycle
      if (bus.cnt_clr)  xcount_q <= '0;
      else if (sum[16]) xcount_q <= 16'hFFFF;
      else              xcount_q <= sum[15:0];
    end
  end

  assign bus.y       = y_l;
  assign bus.xcount  = xcount_q;
  assign bus.settled = settled_q;
endmodule

// File: tb/tb_nor_bank.sv
// Testbench for nor_bank: a 4-channel, 2-input, 3-cycle-delay instance
// checked every rising edge against a queue-based reference model through a
// scoreboard, plus a 1-channel DELAY=1 instance for first-capture timing.
module tb_nor_bank;
  localparam logic [3:0] IV0 = 4'b1010;

  typedef struct packed {
    logic [3:0]  y;
    logic [15:0] xc;
    logic        st;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  nor_bank_if #(.WIDTH(2), .CHANNELS(4)) b0 ();
  nor_bank_if #(.WIDTH(3), .CHANNELS(1)) b1 ();

  nor_bank #(.WIDTH(2), .CHANNELS(4), .IV(IV0), .DELAY(3)) u0 (
    .clk (clk), .rst (rst), .bus (b0)
  );
  nor_bank #(.WIDTH(3), .CHANNELS(1), .IV(1'b0), .DELAY(1)) u1 (
    .clk (clk), .rst (rst), .bus (b1)
  );

  int   n_chk = 0;
  int   n_err = 0;
  exp_t q[$];

  // reference model: y is whatever was captured DELAY active edges ago
  logic [3:0]  m_cap;
  logic [3:0]  m_hist[$];
  logic [15:0] m_xc;
  logic        m_set;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] nor4(input logic [7:0] i);
    logic [3:0] r;
    for (int c = 0; c < 4; c++) r[c] = (i[2*c +: 2] == 2'b00);
    return r;
  endfunction

  task automatic m_reset();
    m_cap  = IV0;
    m_hist = {IV0, IV0, IV0};
    m_xc   = 16'd0;
    m_set  = 1'b0;
  endtask

  task automatic m_rise(input logic c);
    logic [3:0] yo, yn;
    int         s;
    yo = m_hist[0];
    m_hist.push_back(m_cap);
    void'(m_hist.pop_front());
    yn = m_hist[0];
    s  = int'(m_xc) + $countones(yn ^ yo);
    m_xc  = c ? 16'd0 : (s > 65535 ? 16'hFFFF : 16'(s));
    m_set = (m_cap == yn);
    foreach (m_hist[k]) if (m_hist[k] != yn) m_set = 1'b0;
  endtask

  // One clock cycle, entered and left at rising edge + 2.
  task automatic cyc(input logic [7:0] i, input logic h, input logic c, input logic g);
    exp_t e;
    b0.in = i; b0.hold = h; b0.cnt_clr = c;
    if (g) begin
      #1 b0.in = ~i;
      #1 b0.in = i;
    end
    @(negedge clk);
    if (!rst) m_reset();
    else if (!h) m_cap = nor4(i);
    @(posedge clk);
    if (!rst) m_reset();
    else if (!h) m_rise(c);
    e.y = m_hist[0]; e.xc = m_xc; e.st = m_set;
    q.push_back(e);
    #2;
  endtask

  // scoreboard monitor: one expected record per rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("out{y,xcount,settled}", {11'd0, b0.y, b0.xcount, b0.settled}, {11'd0, e});
      end
    end
  end

  // DELAY=1 instance: first capture after reset release, first y update after it
  initial begin
    b1.in = 3'b000; b1.hold = 1'b0; b1.cnt_clr = 1'b0;
    wait (rst === 1'b1);
    @(negedge clk); #1;
    chk("d1 y before first rise", {31'd0, b1.y}, 32'd0);
    @(posedge clk); #1;
    chk("d1 y after first rise", {31'd0, b1.y}, 32'd1);
    chk("d1 xcount", {16'd0, b1.xcount}, 32'd1);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] r;
    logic       tgl;
    m_reset();
    b0.in = 8'h00; b0.hold = 1'b0; b0.cnt_clr = 1'b0;
    @(posedge clk); #2;
    // reset state, clocks ignored
    chk("reset y", {28'd0, b0.y}, {28'd0, IV0});
    chk("reset xcount", {16'd0, b0.xcount}, 32'd0);
    cyc(8'h00, 1'b1, 1'b1, 1'b0);
    cyc(8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    // IV=1010, in=00: y holds IV for 2 edges, all-ones on the 3rd
    cyc(8'h00, 1'b0, 1'b0, 1'b0); chk("d3 y edge1", {28'd0, b0.y}, 32'hA);
    cyc(8'h00, 1'b0, 1'b0, 1'b0); chk("d3 y edge2", {28'd0, b0.y}, 32'hA);
    cyc(8'h00, 1'b0, 1'b0, 1'b0); chk("d3 y edge3", {28'd0, b0.y}, 32'hF);
    chk("d3 xcount", {16'd0, b0.xcount}, 32'd2);
    cyc(8'h00, 1'b0, 1'b0, 1'b0); chk("d3 settled", {31'd0, b0.settled}, 32'd1);

    // glitch between rising and falling edge must be invisible
    cyc(8'h00, 1'b0, 1'b0, 1'b1);
    cyc(8'h00, 1'b0, 1'b0, 1'b1);
    chk("glitch y", {28'd0, b0.y}, 32'hF);
    chk("glitch xcount", {16'd0, b0.xcount}, 32'd2);

    // hold mid-propagation, cnt_clr ignored while held
    cyc(8'hFF, 1'b0, 1'b0, 1'b0);
    repeat (5) cyc(8'h00, 1'b1, 1'b1, 1'b0);
    repeat (4) cyc(8'hFF, 1'b0, 1'b0, 1'b0);
    chk("hold resume y", {28'd0, b0.y}, 32'h0);

    // randomized traffic
    repeat (300) begin
      r = 8'($urandom);
      cyc(r, ($urandom_range(7) == 0), ($urandom_range(15) == 0), ($urandom_range(7) == 0));
    end

    // reset mid-propagation: launched value must never appear
    repeat (4) cyc(8'h00, 1'b0, 1'b0, 1'b0);
    cyc(8'hFF, 1'b0, 1'b0, 1'b0);
    cyc(8'hFF, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    m_reset();
    #1;
    chk("async reset y", {28'd0, b0.y}, {28'd0, IV0});
    chk("async reset xcount", {16'd0, b0.xcount}, 32'd0);
    chk("async reset settled", {31'd0, b0.settled}, 32'd0);
    #1;
    cyc(8'h00, 1'b0, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (5) begin
      cyc(8'h00, 1'b0, 1'b0, 1'b0);
      chk("no stale y", {31'd0, (b0.y == 4'h0)}, 32'd0);
    end

    // saturation: fast preload with all channels toggling, then one channel
    cyc(8'h00, 1'b0, 1'b1, 1'b0);
    tgl = 1'b0;
    while (m_xc < 16'd65500) begin
      cyc(tgl ? 8'hFF : 8'h00, 1'b0, 1'b0, 1'b0);
      tgl = ~tgl;
    end
    while (m_xc < 16'd65534) begin
      cyc(tgl ? 8'h03 : 8'h00, 1'b0, 1'b0, 1'b0);
      tgl = ~tgl;
    end
    chk("preload xcount", {16'd0, b0.xcount}, 32'd65534);
    repeat (2) begin
      cyc(tgl ? 8'h03 : 8'h00, 1'b0, 1'b0, 1'b0);
      tgl = ~tgl;
    end
    chk("sat xcount", {16'd0, b0.xcount}, 32'd65535);
    repeat (3) begin
      cyc(tgl ? 8'h03 : 8'h00, 1'b0, 1'b0, 1'b0);
      tgl = ~tgl;
    end
    chk("sat hold xcount", {16'd0, b0.xcount}, 32'd65535);
    cyc(tgl ? 8'h03 : 8'h00, 1'b0, 1'b1, 1'b0);
    chk("clear wins xcount", {16'd0, b0.xcount}, 32'd0);

    repeat (3) @(posedge clk);
    #3;
    chk("scoreboard drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
